// File: rtl/mem_access_unit_if.sv
// Core-side request/response bundle of the data-memory access unit.
// The core is the master; the access unit is the slave.
interface mem_access_unit_if;
    logic        memread;
    logic        memwrite;
    logic [1:0]  mem_length;
    logic        mem_signed;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        done;
    logic        err;

    modport master (
        output memread, memwrite, mem_length, mem_signed, addr, wdata,
        input  rdata, stall, done, err
    );

    modport slave (
        input  memread, memwrite, mem_length, mem_signed, addr, wdata,
        output rdata, stall, done, err
    );
endinterface

// File: rtl/mem_access_unit.sv
// Data-memory access unit: byte/half/word loads and stores against a word-wide
// synchronous RAM, with sub-word stores done as read-modify-write.
module mem_access_unit #(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    mem_access_unit_if.slave      bus,
    output logic                  o_ram_en,
    output logic                  o_ram_we,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic [31:0]           o_ram_wdata,
    input  logic [31:0]           i_ram_rdata
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRd   = 2'd1,
        StRdw  = 2'd2,
        StWr   = 2'd3
    } state_e;

    state_e                r_state;
    logic [1:0]            r_lane;
    logic [1:0]            r_len;
    logic                  r_signed;
    logic                  r_is_load;
    logic [31:0]           r_wdata;
    logic [31:0]           r_rdata;
    logic                  r_done;
    logic                  r_err;
    logic                  r_ram_en;
    logic                  r_ram_we;
    logic [ADDR_WIDTH-1:0] r_ram_addr;
    logic [31:0]           r_ram_wdata;

    logic                  w_valid;
    logic                  w_reject;
    logic                  w_word_store;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [31:0]           w_load_data;
    logic [31:0]           w_merge_data;
    logic                  w_unused;

    // Upper address bits lie outside the RAM and are ignored.
    assign w_unused = ^bus.addr[31:ADDR_WIDTH+2];

    assign w_valid      = (bus.memread | bus.memwrite) && (bus.mem_length != 2'b00);
    assign w_reject     = (bus.memread && bus.memwrite) ||
                          (bus.mem_length == 2'b10 && bus.addr[0]) ||
                          (bus.mem_length == 2'b11 && bus.addr[1:0] != 2'b00);
    assign w_word_store = bus.memwrite && (bus.mem_length == 2'b11);

    always_comb begin
        w_byte      = i_ram_rdata[{r_lane, 3'b000} +: 8];
        w_half      = r_lane[1] ? i_ram_rdata[31:16] : i_ram_rdata[15:0];
        w_load_data = i_ram_rdata;
        unique case (r_len)
            2'b01:   w_load_data = {{24{r_signed & w_byte[7]}}, w_byte};
            2'b10:   w_load_data = {{16{r_signed & w_half[15]}}, w_half};
            default: w_load_data = i_ram_rdata;
        endcase
    end

    // Store merge: keep the RAM word and replace only the addressed lane.
    always_comb begin
        w_merge_data = i_ram_rdata;
        if (r_len == 2'b01) begin
            w_merge_data[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
        end else if (r_lane[1]) begin
            w_merge_data[31:16] = r_wdata[15:0];
        end else begin
            w_merge_data[15:0] = r_wdata[15:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_lane      <= 2'b00;
            r_len       <= 2'b00;
            r_signed    <= 1'b0;
            r_is_load   <= 1'b0;
            r_wdata     <= 32'h0;
            r_rdata     <= 32'h0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= 32'h0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    // A request still held during its done cycle is not taken again.
                    if (w_valid && !r_done) begin
                        r_lane    <= bus.addr[1:0];
                        r_len     <= bus.mem_length;
                        r_signed  <= bus.mem_signed;
                        r_is_load <= bus.memread;
                        r_wdata   <= bus.wdata;
                        if (w_reject) begin
                            r_done <= 1'b1;
                            r_err  <= 1'b1;
                        end else begin
                            r_ram_en   <= 1'b1;
                            r_ram_addr <= bus.addr[ADDR_WIDTH+1:2];
                            if (w_word_store) begin
                                r_ram_we    <= 1'b1;
                                r_ram_wdata <= bus.wdata;
                                r_state     <= StWr;
                            end else begin
                                r_ram_we <= 1'b0;
                                r_state  <= StRd;
                            end
                        end
                    end
                end
                StRd: begin
                    r_ram_en <= 1'b0;
                    r_state  <= StRdw;
                end
                StRdw: begin
                    if (r_is_load) begin
                        r_rdata <= w_load_data;
                        r_done  <= 1'b1;
                        r_state <= StIdle;
                    end else begin
                        r_ram_wdata <= w_merge_data;
                        r_ram_en    <= 1'b1;
                        r_ram_we    <= 1'b1;
                        r_state     <= StWr;
                    end
                end
                StWr: begin
                    r_ram_en <= 1'b0;
                    r_ram_we <= 1'b0;
                    r_done   <= 1'b1;
                    r_state  <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.rdata   = r_rdata;
    assign bus.done    = r_done;
    assign bus.err     = r_err;
    assign bus.stall   = i_rst_n && ((r_state != StIdle) || (w_valid && !r_done));
    assign o_ram_en    = r_ram_en;
    assign o_ram_we    = r_ram_we;
    assign o_ram_addr  = r_ram_addr;
    assign o_ram_wdata = r_ram_wdata;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Data-memory access unit for the single-cycle MIPS core, sitting between the datapath and a word-wide synchronous data RAM. It performs the byte, halfword and word loads and stores requested by the decoder's `memread`/`memwrite`/`mem_length`/`mem_signed` signals. It also extracts and extends load data, and implements sub-word stores by read-modify-write. It stalls the core until each access completes.

## Interface
- `ADDR_WIDTH`, default 10: RAM word-address width. Byte address bits `[ADDR_WIDTH+1:2]` select the word.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `memread`  in  1  load request.
- `memwrite`  in  1  store request.
- `mem_length`  in  2  access size: 00 none, 01 byte, 10 half, 11 word.
- `mem_signed`  in  1  load extension: 1 sign, 0 zero. Ignored for word accesses and stores.
- `addr`  in  32  byte address, little-endian.
- `wdata`  in  32  store data; byte stores use bits [7:0], half stores use bits [15:0].
- `rdata`  out  32  registered, extended load result.
- `stall`  out  1  combinational; core holds PC and inputs while high.
- `done`  out  1  one-cycle pulse marking completion of the current request.
- `err`  out  1  one-cycle pulse with `done`: misaligned or illegal request.
- `ram_en`  out  1  registered RAM enable.
- `ram_we`  out  1  registered RAM write enable.
- `ram_addr`  out  ADDR_WIDTH  registered RAM word address.
- `ram_wdata`  out  32  registered RAM write word.
- `ram_rdata`  in  32  RAM read word, valid the cycle after the RAM samples `ram_en=1`, `ram_we=0`.

## Operation
- FSM states: IDLE, RD, RDW, WR. The request is valid when `(memread|memwrite) && mem_length!=00`.
- In IDLE with a valid request and `done==0`, the unit accepts the request and captures `addr`, length, signed and `wdata`. A held request during the `done` cycle is not re-accepted.
- Rejection rule: the request is rejected when both `memread` and `memwrite` are high, when a half access has `addr[0]=1`, or when a word access has `addr[1:0]!=0`.
  - A rejected request makes no RAM access.
  - Next cycle: `err=1`, `done=1`, state stays IDLE, `rdata` unchanged.
- Load: IDLE -> RD (`ram_en=1`, `ram_we=0`) -> RDW (`ram_en=0`) -> IDLE.
  - On leaving RDW, `rdata` is loaded from `ram_rdata` and `done=1`.
  - Byte lane is `addr[1:0]`: lane i is bits [8i+7:8i]. Half lane is `addr[1]`: upper half when 1.
  - Result is extended to 32 bits per `mem_signed`.
- Word store: IDLE -> WR (`ram_en=1`, `ram_we=1`, `ram_wdata=wdata`) -> IDLE with `done=1`.
- Byte/half store: IDLE -> RD -> RDW -> WR -> IDLE with `done=1`.
  - In RDW, `ram_wdata` is formed from `ram_rdata` with only the addressed lane replaced.
  - `ram_en`/`ram_we` are raised for WR.
- `stall = rst_n && (state!=IDLE || (valid request && !done))`.
- `rdata` changes only on load completion. Stores and rejected requests leave it unchanged.
- `ram_addr` holds its last value when `ram_en=0`. `ram_we` is never high without `ram_en`.

## Timing
- Reset values: state IDLE; `rdata`=0, `done`=0, `err`=0, `ram_en`=0, `ram_we`=0, `ram_addr`=0, `ram_wdata`=0. `stall`=0 while `rst_n` is low.
- The core presents the request in cycle C0.
- Latency by request type:
  - Load: stall in C0–C2; `done` and valid `rdata` in C3; the core commits at the end of C3.
  - Word store: stall in C0–C1; RAM write sampled at the end of C1; `done` in C2.
  - Byte/half store: stall in C0–C3; RAM write in C3; `done` in C4.
  - Rejected request: stall in C0; `err` and `done` in C1.
- `ram_we` is high for exactly one cycle per store, and is never high for loads or rejected requests.
- Back-to-back requests: the next request is accepted in the cycle after `done`.
- Reset mid-operation returns the unit to IDLE at that edge with all outputs at reset values.
  - A WR phase whose cycle ends at the reset edge completes in RAM.
  - Any earlier phase is abandoned with no RAM write.
- Inputs change only while `stall=0` and are held otherwise. Behaviour on mid-stall input changes is undefined.

## Test plan
- Load extension: RAM word 0 = 0x88442211. `lb` at addr 3 gives `rdata`=0xFFFFFF88 with `done` in C3 and stall in C0–C2. `lbu` at addr 3 gives 0x00000088.
- Half loads: same word. `lh` at addr 2 gives 0xFFFF8844; `lhu` at addr 0 gives 0x00002211. `lw` at addr 0 gives 0x88442211 regardless of `mem_signed`.
- Byte store: `sb` with `wdata`=0x123456AB at addr 1 leaves word 0 = 0x8844AB11. `ram_we` is high for one cycle (C3) and `done` arrives in C4. `sw` 0xDEADBEEF at addr 4 writes in C1 with `done` in C2.
- Rejects: `sw` at addr 5, `lh` at addr 3, and `memread`=`memwrite`=1 each produce `err`=`done`=1 in C1, with no `ram_en` and `rdata` unchanged.
- Reset mid-store: `sh` at addr 2 with reset in RDW leaves RAM unchanged and all outputs 0. A following `lw` at addr 0 completes normally in 4 cycles.
- Hold and back-to-back: a load request held through the `done` cycle is not re-issued (exactly one RD). A new `lbu` presented the cycle after `done` is accepted immediately.
